// File: rtl/antirrebote_multicanal_pkg.sv
// Shared constants for the pushbutton debouncer: system clock rate and the
// helpers used to derive cycle counts from milliseconds.
package antirrebote_multicanal_pkg;

    localparam int CLK_HZ = 12_000_000;

    function automatic int ms_a_ciclos(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One debounced button channel: two-flop synchroniser, stability filter,
// registered edge pulses and long-press / auto-repeat pulse.
module antirrebote_canal
    import antirrebote_multicanal_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = ms_a_ciclos(20),
    parameter int   HOLD_CYCLES     = ms_a_ciclos(1000),
    parameter int   REPEAT_CYCLES   = ms_a_ciclos(200),
    parameter logic NIVEL_REPOSO    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_clean,
    output logic pulso_sube,
    output logic pulso_baja,
    output logic pulso_largo
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_LOAD  = HW'(REPEAT_CYCLES);

    logic          s1;
    logic          s2;
    logic          candidato;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold_tmr;
    logic          cambia;

    // The clean level flips on this edge; a falling edge must win over a repeat.
    assign cambia = (s2 == candidato) && (cnt == CNT_MAX) && (btn_clean != candidato);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= NIVEL_REPOSO;
            s2          <= NIVEL_REPOSO;
            candidato   <= NIVEL_REPOSO;
            btn_clean   <= NIVEL_REPOSO;
            cnt         <= '0;
            hold_tmr    <= HOLD_LOAD;
            pulso_sube  <= 1'b0;
            pulso_baja  <= 1'b0;
            pulso_largo <= 1'b0;
        end else begin
            s1          <= btn;
            s2          <= s1;
            pulso_sube  <= 1'b0;
            pulso_baja  <= 1'b0;
            pulso_largo <= 1'b0;

            if (s2 != candidato) begin
                candidato <= s2;
                cnt       <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else if (btn_clean != candidato) begin
                btn_clean  <= candidato;
                pulso_sube <= candidato;
                pulso_baja <= ~candidato;
            end

            // Down-counter holds the cycles left until the next long-press pulse;
            // zero means expired with repeat disabled.
            if (btn_clean && !cambia) begin
                if (hold_tmr == HW'(1)) begin
                    pulso_largo <= 1'b1;
                    hold_tmr    <= REP_LOAD;
                end else if (hold_tmr != '0) begin
                    hold_tmr <= hold_tmr - 1'b1;
                end
            end else begin
                hold_tmr <= HOLD_LOAD;
            end
        end
    end

endmodule

// File: rtl/antirrebote_multicanal.sv
// N independent debounced button channels; outputs are the per-channel
// signals concatenated by channel index.
module antirrebote_multicanal
    import antirrebote_multicanal_pkg::*;
#(
    parameter int   N_CANALES       = 4,
    parameter int   DEBOUNCE_CYCLES = ms_a_ciclos(20),
    parameter int   HOLD_CYCLES     = ms_a_ciclos(1000),
    parameter int   REPEAT_CYCLES   = ms_a_ciclos(200),
    parameter logic NIVEL_REPOSO    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CANALES-1:0] btn,
    output logic [N_CANALES-1:0] btn_clean,
    output logic [N_CANALES-1:0] pulso_sube,
    output logic [N_CANALES-1:0] pulso_baja,
    output logic [N_CANALES-1:0] pulso_largo
);

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        antirrebote_canal #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .NIVEL_REPOSO    (NIVEL_REPOSO)
        ) u_canal (
            .clk         (clk),
            .rst         (rst),
            .btn         (btn[i]),
            .btn_clean   (btn_clean[i]),
            .pulso_sube  (pulso_sube[i]),
            .pulso_baja  (pulso_baja[i]),
            .pulso_largo (pulso_largo[i])
        );
    end

endmodule

// File: tb/tb_antirrebote_multicanal.sv
// Scoreboard bench: two instances (repeat on / repeat off) share the stimulus;
// a run-length reference model queues expected outputs per edge.
module tb_antirrebote_multicanal;

    localparam int N = 2;
    localparam int D = 8;
    localparam int H = 20;
    localparam int R = 5;

    typedef struct packed {
        logic [N-1:0] clean;
        logic [N-1:0] sube;
        logic [N-1:0] baja;
        logic [N-1:0] largo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] clean_a, sube_a, baja_a, largo_a;
    logic [N-1:0] clean_b, sube_b, baja_b, largo_b;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    antirrebote_multicanal #(
        .N_CANALES(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
        .REPEAT_CYCLES(R), .NIVEL_REPOSO(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .btn(btn), .btn_clean(clean_a),
        .pulso_sube(sube_a), .pulso_baja(baja_a), .pulso_largo(largo_a)
    );

    antirrebote_multicanal #(
        .N_CANALES(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
        .REPEAT_CYCLES(0), .NIVEL_REPOSO(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .btn(btn), .btn_clean(clean_b),
        .pulso_sube(sube_b), .pulso_baja(baja_b), .pulso_largo(largo_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the filter sees the raw input two samples late; the clean
    // level adopts a value once it has been seen on D+2 consecutive edges.
    // Long-press pulses fall at H, H+R, H+2R... edges after the rising edge.
    int   edge_n = 0;
    logic d1[2][N], d2[2][N], last[2][N], mclean[2][N];
    int   run[2][N], rise_t[2][N];

    task automatic model_step(input int di, input int rp, output exp_t e);
        logic seen;
        int   k;
        e = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
                d1[di][ch] = 1'b0; d2[di][ch] = 1'b0; last[di][ch] = 1'b0;
                mclean[di][ch] = 1'b0; run[di][ch] = D + 2; rise_t[di][ch] = 0;
            end else begin
                seen = d2[di][ch];
                d2[di][ch] = d1[di][ch];
                d1[di][ch] = btn[ch];
                run[di][ch] = (seen == last[di][ch]) ? run[di][ch] + 1 : 1;
                last[di][ch] = seen;
                if (run[di][ch] >= D + 2 && seen != mclean[di][ch]) begin
                    mclean[di][ch] = seen;
                    if (seen) begin
                        e.sube[ch] = 1'b1;
                        rise_t[di][ch] = edge_n;
                    end else begin
                        e.baja[ch] = 1'b1;
                    end
                end
                if (mclean[di][ch] && !e.sube[ch]) begin
                    k = edge_n - rise_t[di][ch];
                    if (k == H || (rp > 0 && k > H && (k - H) % rp == 0))
                        e.largo[ch] = 1'b1;
                end
            end
            e.clean[ch] = mclean[di][ch];
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_n++;
            model_step(0, R, e);
            qa.push_back(e);
            model_step(1, 0, e);
            qb.push_back(e);
        end
    end

    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() == 0 || qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty at t=%0t: got 0 entries expected 1", $time);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_clean", 32'(clean_a), 32'(ea.clean));
                chk("a_sube",  32'(sube_a),  32'(ea.sube));
                chk("a_baja",  32'(baja_a),  32'(ea.baja));
                chk("a_largo", 32'(largo_a), 32'(ea.largo));
                chk("b_clean", 32'(clean_b), 32'(eb.clean));
                chk("b_sube",  32'(sube_b),  32'(eb.sube));
                chk("b_baja",  32'(baja_b),  32'(eb.baja));
                chk("b_largo", 32'(largo_b), 32'(eb.largo));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clean_a"}, 32'(clean_a), 32'd0);
        chk({tag, "_pulses_a"}, 32'({sube_a, baja_a, largo_a}), 32'd0);
        chk({tag, "_clean_b"}, 32'(clean_b), 32'd0);
        chk({tag, "_pulses_b"}, 32'({sube_b, baja_b, largo_b}), 32'd0);
    endtask

    initial begin
        int left[N];
        rst = 1'b1;
        btn = '0;
        cyc(3);
        rst = 1'b0;
        cyc(5);

        // clean step on channel 0, long hold with repeats, release
        btn[0] = 1'b1;
        cyc(11 + 65);
        // asynchronous reset between edges while clean is high
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        cyc(2);
        rst = 1'b0;
        cyc(30);
        btn[0] = 1'b0;
        cyc(20);

        // bounce train, then settle high; short low glitch; release
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn[0] = ~btn[0];
            cyc(1);
        end
        btn[0] = 1'b1;
        cyc(15);
        btn[0] = 1'b0;
        cyc(7);
        btn[0] = 1'b1;
        cyc(20);
        btn[0] = 1'b0;
        cyc(20);

        // simultaneous step, channel 1 released mid-hold
        btn = 2'b11;
        cyc(11 + 15);
        btn[1] = 1'b0;
        cyc(45);
        btn = '0;
        cyc(20);

        // reset for one cycle at hold count 10, button kept pressed
        btn[0] = 1'b1;
        cyc(11 + 10);
        rst = 1'b1;
        #1 chk_all_zero("mid_rst");
        cyc(1);
        rst = 1'b0;
        cyc(11 + 30);
        btn[0] = 1'b0;
        cyc(20);

        // randomised bursts of bounces and long holds per channel
        for (int ch = 0; ch < N; ch++) left[ch] = 0;
        repeat (3000) begin
            for (int ch = 0; ch < N; ch++) begin
                if (left[ch] == 0) begin
                    btn[ch] = 1'($urandom_range(0, 1));
                    left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 80))
                                                            : int'($urandom_range(1, 12));
                end
                left[ch]--;
            end
            cyc(1);
        end
        btn = '0;
        cyc(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
